// File: rtl/ocimem_pkg.sv
// ocimem_pkg: shared FSM states, jdo field positions and byte-parity helper for the debug RAM block.
package ocimem_pkg;
   typedef enum logic [2:0] {IDLE, J_WR, J_RD, J_CAP, C_RD, C_DONE, C_WR} state_e;
   localparam int JDO_AUTORD_BIT = 37;
   localparam int JDO_DATA_MSB   = 31;
   function automatic logic [3:0] byte_par(input logic [31:0] d);
      for (int i = 0; i < 4; i++) byte_par[i] = ^d[8*i +: 8];
   endfunction
endpackage

// File: rtl/ocimem_ram.sv
// ocimem_ram: single-port sync RAM, byte enables, 1-cycle read latency.
// OCIMEM_PARITY_EN adds one even-parity bit per byte and a read-side mismatch flag.
module ocimem_ram
   import ocimem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              perr_o
);
   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      rdata_q <= mem[addr_i];
   end
   assign rdata_o = rdata_q;
`ifdef OCIMEM_PARITY_EN
   logic [3:0] par [DEPTH];
   logic [3:0] par_q;
   logic [3:0] wpar;
   assign wpar = byte_par(wdata_i);
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (we_i && be_i[i]) par[addr_i][i] <= wpar[i];
      par_q <= par[addr_i];
   end
   assign perr_o = |(par_q ^ byte_par(rdata_q));
`else
   assign perr_o = 1'b0;
`endif
endmodule

// File: rtl/jtag_debug_ocimem.sv
// jtag_debug_ocimem: debugger (jdo/ocimem strobes) and CPU slave access to a shared debug RAM.
// Parity checking on JTAG reads is enabled by OCIMEM_PARITY_EN inside ocimem_ram.
module jtag_debug_ocimem
   import ocimem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   input  logic [3:0]        cpu_byteenable,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest
);
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   state_e            state_q, state_d;
   logic              pa_q, pa_d, pb_q, pb_d, pr_q, pr_d;
   logic [ADDR_W-1:0] haddr_q;
   logic              hauto_q;
   logic [31:0]       hdata_q;
   logic [31:0]       mondreg_q, mondreg_d, cpu_rd_q, cpu_rd_d;
   logic [ADDR_W-1:0] monareg_q, monareg_d;
   logic              ready_q, ready_d, err_q, err_d;
   logic              svc_a, svc_b, svc_r, svc_c, strobe_any, mon_ok, cpu_ok, cpu_sel;
   logic              ram_we, ram_perr;
   logic [3:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_q;
   logic              unused_jdo;
   assign unused_jdo = ^jdo[JDO_AUTORD_BIT-1:JDO_DATA_MSB+1];
   assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   // One item per IDLE visit; an incoming strobe also holds off the CPU so JTAG wins ties.
   assign svc_a  = state_q == IDLE && pa_q;
   assign svc_b  = state_q == IDLE && !pa_q && pb_q;
   assign svc_r  = state_q == IDLE && !pa_q && !pb_q && pr_q;
   assign svc_c  = state_q == IDLE && !pa_q && !pb_q && !pr_q && !strobe_any && (cpu_read || cpu_write);
   assign mon_ok = {1'b0, monareg_q} < DEPTH_W;
   assign cpu_ok = {1'b0, cpu_address} < DEPTH_W;
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = svc_b ? J_WR : svc_r ? J_RD : svc_c ? (cpu_read ? C_RD : C_WR) : IDLE;
         J_RD:    state_d = J_CAP;
         C_RD:    state_d = C_DONE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      pa_d      = take_action_ocimem_a | (pa_q & ~svc_a);
      pb_d      = take_action_ocimem_b | (pb_q & ~svc_b);
      pr_d      = take_no_action_ocimem_a | (pr_q & ~svc_r) | (svc_a & hauto_q);
      cpu_sel   = svc_c || state_q == C_RD || state_q == C_DONE || state_q == C_WR;
      ram_addr  = cpu_sel ? cpu_address : monareg_q;
      ram_we    = (state_q == J_WR && mon_ok) || (state_q == C_WR && cpu_ok);
      ram_be    = state_q == C_WR ? cpu_byteenable : 4'hF;
      ram_wdata = state_q == C_WR ? cpu_writedata : hdata_q;
      monareg_d = svc_a ? haddr_q : (state_q == J_WR || state_q == J_CAP) ? monareg_q + ADDR_W'(1) : monareg_q;
      ready_d   = svc_a ? 1'b0 : (state_q == J_WR || state_q == J_CAP) ? 1'b1 : ready_q;
      err_d     = svc_a ? 1'b0 : ((state_q == J_WR && !mon_ok) || (state_q == J_CAP && (!mon_ok || ram_perr))) ? 1'b1 : err_q;
      mondreg_d = state_q == J_CAP ? (mon_ok ? ram_q : 32'h0) : mondreg_q;
      cpu_rd_d  = (state_q == C_RD && cpu_ok) ? ram_q : 32'h0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pa_q      <= 1'b0;
         pb_q      <= 1'b0;
         pr_q      <= 1'b0;
         haddr_q   <= '0;
         hauto_q   <= 1'b0;
         hdata_q   <= 32'h0;
         mondreg_q <= 32'h0;
         monareg_q <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         cpu_rd_q  <= 32'h0;
      end else begin
         pa_q      <= pa_d;
         pb_q      <= pb_d;
         pr_q      <= pr_d;
         if (take_action_ocimem_a) haddr_q <= jdo[ADDR_W-1:0];
         if (take_action_ocimem_a) hauto_q <= jdo[JDO_AUTORD_BIT];
         if (take_action_ocimem_b) hdata_q <= jdo[JDO_DATA_MSB:0];
         mondreg_q <= mondreg_d;
         monareg_q <= monareg_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         cpu_rd_q  <= cpu_rd_d;
      end
   ocimem_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .be_i    (ram_be),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_q),
      .perr_o  (ram_perr)
   );
   assign MonDReg         = mondreg_q;
   assign MonAReg         = monareg_q;
   assign monitor_ready   = ready_q;
   assign monitor_error   = err_q;
   assign cpu_readdata    = cpu_rd_q;
   assign cpu_waitrequest = !(state_q == C_DONE || state_q == C_WR);
endmodule

// File: tb/tb_jtag_debug_ocimem.sv
// tb_jtag_debug_ocimem: directed vectors with hand-computed expectations, DEPTH=200 so the
// out-of-range and wrap cases are reachable.
module tb_jtag_debug_ocimem;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [37:0] jdo = '0;
   logic        ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
   logic [31:0] MonDReg;
   logic [7:0]  MonAReg;
   logic        monitor_ready, monitor_error;
   logic [7:0]  cpu_address = '0;
   logic        cpu_read = 1'b0, cpu_write = 1'b0;
   logic [31:0] cpu_writedata = '0;
   logic [3:0]  cpu_byteenable = '0;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   int          n_vec = 0, n_err = 0;
   logic [31:0] rd;
   int          lat;
   jtag_debug_ocimem #(.ADDR_W(8), .DEPTH(200)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (ta_a),
      .take_action_ocimem_b    (ta_b),
      .take_no_action_ocimem_a (tn_a),
      .MonDReg                 (MonDReg),
      .MonAReg                 (MonAReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .cpu_address             (cpu_address),
      .cpu_read                (cpu_read),
      .cpu_write               (cpu_write),
      .cpu_writedata           (cpu_writedata),
      .cpu_byteenable          (cpu_byteenable),
      .cpu_readdata            (cpu_readdata),
      .cpu_waitrequest         (cpu_waitrequest)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic strobe(input logic a, input logic b, input logic r, input logic [37:0] v);
      jdo = v; ta_a = a; ta_b = b; tn_a = r;
      @(posedge clk); #1;
      ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
   endtask
   task automatic jload(input logic [7:0] a, input logic auto_rd);
      strobe(1, 0, 0, {auto_rd, 29'h0, a});
      cyc(auto_rd ? 4 : 1);
   endtask
   task automatic jwrite(input logic [31:0] d);
      strobe(0, 1, 0, {6'h0, d});
      cyc(2);
   endtask
   task automatic jread();
      strobe(0, 0, 1, '0);
      cyc(3);
   endtask
   task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d, output int n);
      cpu_address = a; cpu_read = 1'b1; n = 0; d = 'x;
      while (n < 20) begin
         @(posedge clk); #1;
         ta_b = 1'b0;
         n++;
         if (!cpu_waitrequest) break;
      end
      if (cpu_waitrequest) check("cpu_rd_timeout", 32'(n), 32'(0));
      d = cpu_readdata;
      cpu_read = 1'b0;
      @(posedge clk); #1;
      check("cpu_rd_wreq_back", 32'(cpu_waitrequest), 32'(1));
      check("cpu_rd_data_gone", cpu_readdata, 32'h0);
   endtask
   task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      int n = 0;
      cpu_address = a; cpu_write = 1'b1; cpu_writedata = d; cpu_byteenable = be;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (!cpu_waitrequest) break;
      end
      check("cpu_wr_lat", 32'(n), 32'(1));
      cpu_write = 1'b0;
      cyc(1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      cyc(2);
      check("rst_mondreg", MonDReg, 32'h0);
      check("rst_monareg", 32'(MonAReg), 32'h0);
      check("rst_ready", 32'(monitor_ready), 32'h0);
      check("rst_error", 32'(monitor_error), 32'h0);
      check("rst_cpu_rd", cpu_readdata, 32'h0);
      check("rst_wreq", 32'(cpu_waitrequest), 32'h1);
      reset = 1'b0;
      cyc(1);
      // load, write, auto-read back
      jload(8'h10, 0);
      check("t1_areg", 32'(MonAReg), 32'h10);
      strobe(0, 1, 0, {6'h0, 32'hCAFE0001});
      cyc(1);
      check("t1_wr_not_yet", 32'(monitor_ready), 32'h0);
      cyc(1);
      check("t1_wr_ready", 32'(monitor_ready), 32'h1);
      check("t1_wr_areg", 32'(MonAReg), 32'h11);
      strobe(1, 0, 0, {1'b1, 29'h0, 8'h10});
      cyc(3);
      check("t1_rd_not_yet", 32'(monitor_ready), 32'h0);
      cyc(1);
      check("t1_mondreg", MonDReg, 32'hCAFE0001);
      check("t1_ready", 32'(monitor_ready), 32'h1);
      check("t1_areg_inc", 32'(MonAReg), 32'h11);
      check("t1_err", 32'(monitor_error), 32'h0);
      // CPU read of JTAG-written data
      jload(8'h20, 0);
      jwrite(32'hA5A50020);
      jwrite(32'h5A5A0021);
      cpu_rd(8'h21, rd, lat);
      check("t2_cpu_data", rd, 32'h5A5A0021);
      check("t2_cpu_lat", 32'(lat), 32'h2);
      // CPU byte-enable write merged over preloaded word
      jload(8'h05, 0);
      jwrite(32'hFFFFFFFF);
      cpu_wr(8'h05, 32'h11223344, 4'b0101);
      jload(8'h05, 1);
      check("t3_merge", MonDReg, 32'hFF22FF44);
      // out of range
      jload(8'hC8, 0);
      check("t4_err_pre", 32'(monitor_error), 32'h0);
      jread();
      check("t4_mondreg", MonDReg, 32'h0);
      check("t4_err", 32'(monitor_error), 32'h1);
      check("t4_ready", 32'(monitor_ready), 32'h1);
      cpu_rd(8'hC8, rd, lat);
      check("t4_cpu_oor", rd, 32'h0);
      jload(8'h00, 0);
      check("t4_err_clr", 32'(monitor_error), 32'h0);
      jwrite(32'h00000ABC);
      // wrap at top of address space
      jload(8'hFF, 0);
      jwrite(32'hDEADBEEF);
      check("t5_wrap", 32'(MonAReg), 32'h0);
      check("t5_oor_wr_err", 32'(monitor_error), 32'h1);
      jread();
      check("t5_rd0", MonDReg, 32'h00000ABC);
      check("t5_areg1", 32'(MonAReg), 32'h1);
      // simultaneous JTAG write strobe and CPU read of the same word
      jload(8'h00, 0);
      jdo = {6'h0, 32'h12345678}; ta_b = 1'b1;
      cpu_rd(8'h00, rd, lat);
      check("t5_order_data", rd, 32'h12345678);
      check("t5_stalled", 32'(lat > 2), 32'h1);
      check("t5_jwr_done", 32'(monitor_ready), 32'h1);
      // reset during J_RD with a write strobe pending
      strobe(0, 0, 1, '0);
      jdo = {6'h0, 32'hBAD0BAD0}; ta_b = 1'b1;
      @(posedge clk); #1;
      ta_b = 1'b0;
      reset = 1'b1;
      #1;
      check("t6_mondreg", MonDReg, 32'h0);
      check("t6_areg", 32'(MonAReg), 32'h0);
      check("t6_ready", 32'(monitor_ready), 32'h0);
      check("t6_err", 32'(monitor_error), 32'h0);
      check("t6_wreq", 32'(cpu_waitrequest), 32'h1);
      cyc(2);
      reset = 1'b0;
      cyc(5);
      check("t6_no_pending", 32'(monitor_ready), 32'h0);
      check("t6_areg_idle", 32'(MonAReg), 32'h0);
      jload(8'h00, 1);
      check("t6_ram_kept", MonDReg, 32'h12345678);
      jload(8'h05, 1);
      check("t6_ram_kept5", MonDReg, 32'hFF22FF44);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
